// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter.
// Words written through WR_EN/WR_DATA queue in a small FIFO. The transmitter
// pops one word whenever it is idle, latches the line configuration with it,
// and shifts out start, data (LSB first), optional parity and one or two stop
// bits. Each bit lasts BAUD_DIV+1 clock cycles.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVERFLOW,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_wr;
  logic                  w_pop;

  // Frame registers, loaded when a word is popped
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic                  r_stop2;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  w_shift;

  // Transmitter FSM
  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_tmr;
  logic [DIV_WIDTH-1:0]  w_tmr_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  w_bit_end;

  // A write is accepted only when there is room; a pop in the same cycle does not help.
  assign w_wr      = WR_EN & ~r_full;
  assign w_bit_end = (r_tmr == r_div);

  // Occupancy after this cycle's write and pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage write port.
  // NOTE: the memory array has no reset; occupancy is tracked by pointers and
  // count, so stale contents are never read and a reset on the array would
  // only prevent it mapping onto RAM.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= WR_DATA;
    end
  end

  // FIFO pointers, count, registered flags and overflow pulse.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH_CNT);
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= WR_EN & r_full;
    end
  end

  // Frame latch on pop, then shift data right as each data bit completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_div     <= '0;
    end else if (w_pop) begin
      r_shift   <= r_mem[r_rd_ptr];
      r_par_bit <= (^r_mem[r_rd_ptr]) ^ PAR_TYP;
      r_par_en  <= PAR_EN;
      r_stop2   <= STOP2;
      r_div     <= BAUD_DIV;
    end else if (w_shift) begin
      r_shift   <= r_shift >> 1;
    end
  end

  // FSM state, bit timer, bit index and registered serial output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next state, next line level and pop/shift strobes. The line level is
  // computed for the coming state so TX_OUT changes together with the state.
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + DIV_WIDTH'(1);
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_idx_nxt   = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tmr_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_tmr_nxt = '0;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            w_shift   = 1'b1;
            w_tx_nxt  = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tmr_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_tmr_nxt = '0;
          if (r_stop2 && (r_idx == '0)) begin
            w_idx_nxt = IDX_W'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign FULL     = r_full;
  assign EMPTY    = r_empty;
  assign OVERFLOW = r_overflow;
  assign TX_OUT   = r_tx;
  assign BUSY     = (r_state != S_IDLE) | ~r_empty;

endmodule
